gsm_sms_tx: RTL

GSM_SMS_TX -- requirements
Module: gsm_sms_tx

---
 rtl/gsm_sms_tx_if.sv | 11 +
 rtl/gsm_sms_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gsm_sms_tx_if.sv
// rtl/gsm_sms_tx_if.sv - MCU-side request/data and modem-side UART signals of the SMS sender
interface gsm_sms_tx_if;
   logic        send_req;
   logic [15:0] energy_units;
   logic        tx;
   logic        busy;
   logic        done;

   modport master (output send_req, output energy_units, input tx, input busy, input done);
   modport slave  (input send_req, input energy_units, output tx, output busy, output done);
endinterface

// File: rtl/gsm_sms_tx.sv
// rtl/gsm_sms_tx.sv - energy reading to BCD, sent as an ASCII 8N1 UART message to a GSM modem
// Optional feature macro: GSM_SMS_BILL_EN (appends ",B=" and a 6-digit bill of units*5)
module gsm_sms_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   gsm_sms_tx_if.slave    sms
);

`ifdef GSM_SMS_BILL_EN
   localparam int BIN_W   = 19;
   localparam int MSG_LEN = 17;
`else
   localparam int BIN_W   = 16;
   localparam int MSG_LEN = 8;
`endif
   localparam logic [4:0]  LAST_ITER = 5'(BIN_W - 1);
   localparam logic [4:0]  LAST_BYTE = 5'(MSG_LEN);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] STOP_LAST = 16'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_CONVERT, S_START, S_DATA, S_STOP, S_NEXT, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               req_prev_q, armed_q;
   logic               tx_q, tx_d;
   logic [4:0]         conv_cnt_q, conv_cnt_d;
   logic [4:0]         byte_cnt_q, byte_cnt_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [15:0]        clk_cnt_q, clk_cnt_d;
   logic [7:0]         shreg_q, shreg_d;
   logic [BIN_W-1:0]   en_bin_q, en_bin_d;
   logic [23:0]        en_bcd_q, en_bcd_d;
   logic [BIN_W+23:0]  en_sh;
`ifdef GSM_SMS_BILL_EN
   logic [18:0]        bl_bin_q, bl_bin_d;
   logic [23:0]        bl_bcd_q, bl_bcd_d;
   logic [42:0]        bl_sh;
`endif
   logic               trigger;
   logic [7:0]         msg_byte;
   logic               busy_c, done_c;

   function automatic logic [23:0] add3(input logic [23:0] b);
      logic [23:0] r;
      r = b;
      for (int i = 0; i < 6; i++)
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      return r;
   endfunction

   function automatic logic [7:0] asc(input logic [3:0] d);
      return 8'h30 + {4'b0000, d};
   endfunction

   // armed_q masks the first edge after reset so a level held through reset never triggers
   assign trigger = sms.send_req && !req_prev_q && armed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_prev_q <= 1'b0;
         armed_q    <= 1'b0;
         tx_q       <= 1'b1;
         conv_cnt_q <= '0;
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         clk_cnt_q  <= '0;
         shreg_q    <= '0;
         en_bin_q   <= '0;
         en_bcd_q   <= '0;
`ifdef GSM_SMS_BILL_EN
         bl_bin_q   <= '0;
         bl_bcd_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         req_prev_q <= sms.send_req;
         armed_q    <= 1'b1;
         tx_q       <= tx_d;
         conv_cnt_q <= conv_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         clk_cnt_q  <= clk_cnt_d;
         shreg_q    <= shreg_d;
         en_bin_q   <= en_bin_d;
         en_bcd_q   <= en_bcd_d;
`ifdef GSM_SMS_BILL_EN
         bl_bin_q   <= bl_bin_d;
         bl_bcd_q   <= bl_bcd_d;
`endif
      end
   end

   always_comb begin
      msg_byte = 8'h0D;
      case (byte_cnt_q)
         5'd0:    msg_byte = 8'h45;
         5'd1:    msg_byte = 8'h3D;
         5'd2:    msg_byte = asc(en_bcd_q[19:16]);
         5'd3:    msg_byte = asc(en_bcd_q[15:12]);
         5'd4:    msg_byte = asc(en_bcd_q[11:8]);
         5'd5:    msg_byte = asc(en_bcd_q[7:4]);
         5'd6:    msg_byte = asc(en_bcd_q[3:0]);
`ifdef GSM_SMS_BILL_EN
         5'd7:    msg_byte = 8'h2C;
         5'd8:    msg_byte = 8'h42;
         5'd9:    msg_byte = 8'h3D;
         5'd10:   msg_byte = asc(bl_bcd_q[23:20]);
         5'd11:   msg_byte = asc(bl_bcd_q[19:16]);
         5'd12:   msg_byte = asc(bl_bcd_q[15:12]);
         5'd13:   msg_byte = asc(bl_bcd_q[11:8]);
         5'd14:   msg_byte = asc(bl_bcd_q[7:4]);
         5'd15:   msg_byte = asc(bl_bcd_q[3:0]);
`endif
         default: msg_byte = 8'h0D;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      conv_cnt_d = conv_cnt_q;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      clk_cnt_d  = clk_cnt_q;
      shreg_d    = shreg_q;
      en_bin_d   = en_bin_q;
      en_bcd_d   = en_bcd_q;
      en_sh      = {add3(en_bcd_q), en_bin_q} << 1;
`ifdef GSM_SMS_BILL_EN
      bl_bin_d   = bl_bin_q;
      bl_bcd_d   = bl_bcd_q;
      bl_sh      = {add3(bl_bcd_q), bl_bin_q} << 1;
`endif
      case (state_q)
         S_IDLE: if (trigger) begin
            state_d    = S_CONVERT;
            conv_cnt_d = '0;
            en_bin_d   = BIN_W'(sms.energy_units);
            en_bcd_d   = '0;
`ifdef GSM_SMS_BILL_EN
            bl_bin_d   = {3'b000, sms.energy_units} + {1'b0, sms.energy_units, 2'b00};
            bl_bcd_d   = '0;
`endif
         end
         S_CONVERT: begin
            en_bcd_d = en_sh[BIN_W+23:BIN_W];
            en_bin_d = en_sh[BIN_W-1:0];
`ifdef GSM_SMS_BILL_EN
            bl_bcd_d = bl_sh[42:19];
            bl_bin_d = bl_sh[18:0];
`endif
            if (conv_cnt_q == LAST_ITER) begin
               state_d    = S_NEXT;
               byte_cnt_d = '0;
            end else begin
               conv_cnt_d = conv_cnt_q + 5'd1;
            end
         end
         // NEXT doubles as the final cycle of each stop bit, so bytes run back to back
         S_NEXT: if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_DONE;
         end else begin
            state_d   = S_START;
            shreg_d   = msg_byte;
            clk_cnt_d = '0;
         end
         S_START: if (clk_cnt_q == BIT_LAST) begin
            state_d   = S_DATA;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
         end else begin
            clk_cnt_d = clk_cnt_q + 16'd1;
         end
         S_DATA: if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_d = '0;
            if (bit_cnt_q == 3'd7) begin
               state_d = S_STOP;
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               shreg_d   = {1'b0, shreg_q[7:1]};
            end
         end else begin
            clk_cnt_d = clk_cnt_q + 16'd1;
         end
         S_STOP: if (clk_cnt_q == STOP_LAST) begin
            state_d    = S_NEXT;
            byte_cnt_d = byte_cnt_q + 5'd1;
         end else begin
            clk_cnt_d = clk_cnt_q + 16'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shreg_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state_q)
         S_CONVERT, S_START, S_DATA, S_STOP, S_NEXT: busy_c = 1'b1;
         S_DONE:  done_c = 1'b1;
         default: ;
      endcase
   end

   assign sms.tx   = tx_q;
   assign sms.busy = busy_c;
   assign sms.done = done_c;

endmodule
